// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, the memory-tester state type and the pattern LFSR step.
package ahb_lite_pkg;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;
    localparam logic [2:0]  HBURST_SINGLE = 3'b000;
    localparam logic [31:0] LFSR_TAPS     = 32'h80200003;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_ADDR,
        S_W_DATA,
        S_R_ADDR,
        S_R_DATA,
        S_DONE
    } memtest_state_e;

    // Galois right-shift step
    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return {1'b0, l[31:1]} ^ (l[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/ahb_lite_mem_tester_lfsr.sv
// 32-bit pattern generator: load takes priority over step; reset value is a parameter.
module memtest_lfsr32
    import ahb_lite_pkg::*;
#(
    parameter logic [31:0] RESET_VALUE = 32'h00000001
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [31:0] i_seed,
    output logic [31:0] o_value
);

    logic [31:0] r_lfsr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lfsr <= RESET_VALUE;
        end else if (i_load) begin
            r_lfsr <= i_seed;
        end else if (i_step) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_value = r_lfsr;

endmodule

// File: rtl/ahb_lite_mem_tester.sv
// AHB-Lite master that writes an LFSR pattern over a window, reads it back and counts errors.
// Optional macro MEMTEST_STOP_ON_ERR_EN: end the run at the first error.
module ahb_lite_mem_tester
    import ahb_lite_pkg::*;
#(
    parameter int unsigned            HADDR_BITS = 25,
    parameter logic [HADDR_BITS-1:0]  START_ADDR = '0,
    parameter int unsigned            ADDR_STEP  = 2,
    parameter int unsigned            WORD_COUNT = 1024,
    parameter logic [31:0]            LFSR_SEED  = 32'h00000001
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  START,
    output logic [HADDR_BITS-1:0] HADDR,
    output logic [2:0]            HBURST,
    output logic [2:0]            HSIZE,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [31:0]           HWDATA,
    input  logic [31:0]           HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  PASS,
    output logic [15:0]           ERR_COUNT,
    output logic [HADDR_BITS-1:0] FIRST_ERR_ADDR
);

    localparam int unsigned IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

    generate
        if (WORD_COUNT == 0) begin : g_bad_word_count
            $error("WORD_COUNT must be at least 1");
        end
        if (LFSR_SEED == 32'h0) begin : g_bad_seed
            $error("LFSR_SEED must be nonzero");
        end
    endgenerate

    memtest_state_e        r_state, w_state_nxt;
    logic [HADDR_BITS-1:0] r_addr, w_addr_nxt;
    logic [IDX_W-1:0]      r_idx, w_idx_nxt;
    logic [15:0]           r_err_cnt, w_err_cnt_nxt;
    logic [HADDR_BITS-1:0] r_first, w_first_nxt;
    logic                  w_lfsr_load, w_lfsr_step, w_err;
    logic [31:0]           w_lfsr;

    memtest_lfsr32 #(.RESET_VALUE(LFSR_SEED)) u_lfsr (
        .i_clk   (HCLK),
        .i_rst   (HRESET),
        .i_load  (w_lfsr_load),
        .i_step  (w_lfsr_step),
        .i_seed  (LFSR_SEED),
        .o_value (w_lfsr)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_idx     <= '0;
            r_err_cnt <= '0;
            r_first   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_idx     <= w_idx_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_first   <= w_first_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_idx_nxt     = r_idx;
        w_err_cnt_nxt = r_err_cnt;
        w_first_nxt   = r_first;
        w_lfsr_load   = 1'b0;
        w_lfsr_step   = 1'b0;
        w_err         = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    w_state_nxt   = S_W_ADDR;
                    w_addr_nxt    = START_ADDR;
                    w_idx_nxt     = '0;
                    w_err_cnt_nxt = '0;
                    w_first_nxt   = '0;
                    w_lfsr_load   = 1'b1;
                end
            end
            S_W_ADDR: if (HREADY) w_state_nxt = S_W_DATA;
            S_R_ADDR: if (HREADY) w_state_nxt = S_R_DATA;
            S_W_DATA, S_R_DATA: begin
                if (HREADY) begin
                    w_err = HRESP || ((r_state == S_R_DATA) && (HRDATA != w_lfsr));
                    if (w_err) begin
                        if (r_err_cnt != '1) w_err_cnt_nxt = r_err_cnt + 16'd1;
                        if (r_err_cnt == '0) w_first_nxt = r_addr;
                    end
                    // End of the write pass rewinds; every other completion advances.
                    if ((r_idx == LAST_IDX) && (r_state == S_W_DATA)) begin
                        w_state_nxt = S_R_ADDR;
                        w_addr_nxt  = START_ADDR;
                        w_idx_nxt   = '0;
                        w_lfsr_load = 1'b1;
                    end else begin
                        w_lfsr_step = 1'b1;
                        w_addr_nxt  = r_addr + HADDR_BITS'(ADDR_STEP);
                        if (r_idx == LAST_IDX) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_idx_nxt   = r_idx + IDX_W'(1);
                            w_state_nxt = (r_state == S_W_DATA) ? S_W_ADDR : S_R_ADDR;
                        end
                    end
`ifdef MEMTEST_STOP_ON_ERR_EN
                    if (w_err) w_state_nxt = S_DONE;
`else
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign HADDR          = r_addr;
    assign HBURST         = HBURST_SINGLE;
    assign HSIZE          = HSIZE_WORD;
    assign HTRANS         = ((r_state == S_W_ADDR) || (r_state == S_R_ADDR)) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HWRITE         = (r_state == S_W_ADDR);
    assign HWDATA         = (r_state == S_W_DATA) ? w_lfsr : '0;
    assign BUSY           = (r_state == S_W_ADDR) || (r_state == S_W_DATA) ||
                            (r_state == S_R_ADDR) || (r_state == S_R_DATA);
    assign DONE           = (r_state == S_DONE);
    assign PASS           = DONE && (r_err_cnt == '0);
    assign ERR_COUNT      = r_err_cnt;
    assign FIRST_ERR_ADDR = r_first;

endmodule
